// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding, main-entry
// update selector, default bubble payload and a saturating add for counters.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MAIN_HOLD  = 2'd0,
      MAIN_IN    = 2'd1,
      MAIN_SKID  = 2'd2,
      MAIN_CLEAR = 2'd3
   } main_sel_e;

   localparam logic [31:0] BUBBLE_DEFAULT = 32'h0000_0000;

   localparam int SAT_W = 64;

   // Adds inc to val, clamping the result at lim.
   function automatic logic [SAT_W-1:0] sat_add(
      input logic [SAT_W-1:0] val,
      input logic [SAT_W-1:0] inc,
      input logic [SAT_W-1:0] lim
   );
      logic [SAT_W-1:0] sum;
      sum = val + inc;
      if (sum > lim) begin
         return lim;
      end else begin
         return sum;
      end
   endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle between an upstream producer, the elastic stage and its consumer.
// master = environment side, slave = the stage itself.
interface pipe_stage_elastic_if #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32
);
   logic              In_Valid;
   logic              In_Ready;
   logic [PC_W-1:0]   In_PC;
   logic [DATA_W-1:0] In_Data;
   logic              Flush;
   logic              Out_Valid;
   logic              Out_Ready;
   logic [PC_W-1:0]   Out_PC;
   logic [DATA_W-1:0] Out_Data;
   logic [1:0]        Occupancy;

   modport master (
      output In_Valid, In_PC, In_Data, Flush, Out_Ready,
      input  In_Ready, Out_Valid, Out_PC, Out_Data, Occupancy
   );

   modport slave (
      input  In_Valid, In_PC, In_Data, Flush, Out_Ready,
      output In_Ready, Out_Valid, Out_PC, Out_Data, Occupancy
   );
endinterface

// File: rtl/pipe_perf_counter.sv
// Single saturating performance counter; adds i_inc each cycle, clears on reset only.
module pipe_perf_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int INC_W = 2
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [INC_W-1:0] i_inc,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_cnt_nxt = CNT_W'(sat_add(SAT_W'(r_cnt), SAT_W'(i_inc), SAT_W'({CNT_W{1'b1}})));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer and flush-to-bubble.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int                PC_W        = 32,
   parameter int                DATA_W      = 32,
   parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(BUBBLE_DEFAULT)
`ifdef PIPE_PERF_CNT_EN
   ,
   parameter int                CNT_W       = 16
`endif
)(
   input  logic                Clk,
   input  logic                Reset,
   pipe_stage_elastic_if.slave bus
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    Stall_Cnt,
   output logic [CNT_W-1:0]    Flush_Cnt
`endif
);
   state_e            r_state;
   state_e            w_state_nxt;
   main_sel_e         w_main_sel;
   logic              w_skid_load;
   logic              w_accept;
   logic              w_pop;
   logic              r_in_ready;
   logic [PC_W-1:0]   r_main_pc;
   logic [DATA_W-1:0] r_main_data;
   logic [PC_W-1:0]   r_skid_pc;
   logic [DATA_W-1:0] r_skid_data;

   assign w_accept = bus.In_Valid & r_in_ready;
   assign w_pop    = (r_state != ST_EMPTY) & bus.Out_Ready;

   // In_Ready is registered from the next state so Out_Ready never reaches it combinationally.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_main_sel  = MAIN_HOLD;
      w_skid_load = 1'b0;
      if (bus.Flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_sel  = MAIN_CLEAR;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_main_sel  = MAIN_IN;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (w_accept && !w_pop) begin
                  w_state_nxt = ST_FULL;
                  w_skid_load = 1'b1;
               end else if (w_accept && w_pop) begin
                  w_state_nxt = ST_ONE;
                  w_main_sel  = MAIN_IN;
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
                  w_main_sel  = MAIN_CLEAR;
               end else begin
                  w_state_nxt = ST_ONE;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  w_state_nxt = ST_ONE;
                  w_main_sel  = MAIN_SKID;
               end else begin
                  w_state_nxt = ST_FULL;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_main_sel  = MAIN_CLEAR;
            end
         endcase
      end
   end

   // Main entry drives Out_* directly; it reverts to the bubble pattern whenever it empties.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_main_pc   <= '0;
         r_main_data <= BUBBLE_DATA;
      end else begin
         case (w_main_sel)
            MAIN_IN: begin
               r_main_pc   <= bus.In_PC;
               r_main_data <= bus.In_Data;
            end
            MAIN_SKID: begin
               r_main_pc   <= r_skid_pc;
               r_main_data <= r_skid_data;
            end
            MAIN_CLEAR: begin
               r_main_pc   <= '0;
               r_main_data <= BUBBLE_DATA;
            end
            default: begin
               r_main_pc   <= r_main_pc;
               r_main_data <= r_main_data;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_skid_pc   <= '0;
         r_skid_data <= BUBBLE_DATA;
      end else if (w_skid_load) begin
         r_skid_pc   <= bus.In_PC;
         r_skid_data <= bus.In_Data;
      end else begin
         r_skid_pc   <= r_skid_pc;
         r_skid_data <= r_skid_data;
      end
   end

   assign bus.In_Ready  = r_in_ready;
   assign bus.Out_Valid = (r_state != ST_EMPTY);
   assign bus.Out_PC    = r_main_pc;
   assign bus.Out_Data  = r_main_data;
   assign bus.Occupancy = r_state;

`ifdef PIPE_PERF_CNT_EN
   logic [1:0] w_stall_inc;
   logic [1:0] w_flush_inc;

   // A flush discards every held entry plus the offered one, whether or not it was acceptable.
   assign w_stall_inc = {1'b0, (r_state != ST_EMPTY) & ~bus.Out_Ready};
   assign w_flush_inc = bus.Flush ? (2'(r_state) + {1'b0, bus.In_Valid}) : 2'd0;

   pipe_perf_counter #(.CNT_W(CNT_W), .INC_W(2)) u_stall_cnt (
      .i_clk   (Clk),
      .i_reset (Reset),
      .i_inc   (w_stall_inc),
      .o_cnt   (Stall_Cnt)
   );

   pipe_perf_counter #(.CNT_W(CNT_W), .INC_W(2)) u_flush_cnt (
      .i_clk   (Clk),
      .i_reset (Reset),
      .i_inc   (w_flush_inc),
      .o_cnt   (Flush_Cnt)
   );
`endif
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised bench for pipe_stage_elastic against a queue-based FIFO model,
// with directed literal checks for reset, streaming, skid, flush and saturation.
module tb_pipe_stage_elastic;
   localparam int          PC_W   = 32;
   localparam int          DATA_W = 32;
   localparam logic [31:0] BUB    = 32'h0000_0013;
   localparam int          CMAX   = 15;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_stage_elastic_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

`ifdef PIPE_PERF_CNT_EN
   logic [3:0] stall_cnt;
   logic [3:0] flush_cnt;
`endif

   pipe_stage_elastic #(
      .PC_W        (PC_W),
      .DATA_W      (DATA_W),
      .BUBBLE_DATA (BUB)
`ifdef PIPE_PERF_CNT_EN
      ,
      .CNT_W       (4)
`endif
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
`ifdef PIPE_PERF_CNT_EN
      ,
      .Stall_Cnt (stall_cnt),
      .Flush_Cnt (flush_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two entries plus the ready flag and counters.
   ent_t q[$];
   logic m_rdy = 1'b0;
   int   m_stall = 0;
   int   m_flush = 0;

   initial begin
      forever begin
         @(posedge clk);
         begin
            int  occ;
            bit  acc;
            ent_t e;
            occ = q.size();
            if (rst) begin
               q.delete();
               m_rdy   = 1'b0;
               m_stall = 0;
               m_flush = 0;
            end else begin
               if (occ > 0 && !bus.Out_Ready) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
               if (bus.Flush) begin
                  m_flush = m_flush + occ + (bus.In_Valid ? 1 : 0);
                  if (m_flush > CMAX) m_flush = CMAX;
                  q.delete();
               end else begin
                  acc = bus.In_Valid && m_rdy;
                  e.pc   = bus.In_PC;
                  e.data = bus.In_Data;
                  if (occ > 0 && bus.Out_Ready) void'(q.pop_front());
                  if (acc) q.push_back(e);
               end
               m_rdy = (q.size() < 2);
            end
         end
         #2;
         chk("in_ready",  32'(bus.In_Ready),  32'(m_rdy));
         chk("out_valid", 32'(bus.Out_Valid), (q.size() > 0) ? 32'd1 : 32'd0);
         chk("occupancy", 32'(bus.Occupancy), 32'(q.size()));
         chk("out_pc",    bus.Out_PC,   (q.size() > 0) ? q[0].pc   : 32'd0);
         chk("out_data",  bus.Out_Data, (q.size() > 0) ? q[0].data : BUB);
`ifdef PIPE_PERF_CNT_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic offer(input logic [31:0] pc);
      bus.In_Valid = 1'b1;
      bus.In_PC    = pc;
      bus.In_Data  = pc ^ 32'hA5A5_0000;
   endtask

   logic [31:0] rpc;

   initial begin
      rst           = 1'b1;
      bus.Flush     = 1'b0;
      bus.Out_Ready = 1'b1;
      offer(32'h100);

      // Reset held three cycles with a valid offer present.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_valid", 32'(bus.Out_Valid), 32'd0);
         chk("rst_data",  bus.Out_Data, BUB);
         chk("rst_occ",   32'(bus.Occupancy), 32'd0);
         chk("rst_ready", 32'(bus.In_Ready), 32'd0);
      end
      rst = 1'b0;
      bus.In_Valid = 1'b0;
      step();
      chk("rel_ready", 32'(bus.In_Ready), 32'd1);

      // Streaming at full rate.
      for (int i = 1; i <= 3; i++) begin
         offer(32'(4 * i));
         step();
         chk("stream_pc",  bus.Out_PC, 32'(4 * i));
         chk("stream_occ", 32'(bus.Occupancy), 32'd1);
      end
      bus.In_Valid = 1'b0;
      step();

      // Downstream stall fills the skid entry.
      bus.Out_Ready = 1'b0;
      offer(32'h10);
      step();
      chk("stall_pc0", bus.Out_PC, 32'h10);
      chk("stall_rdy0", 32'(bus.In_Ready), 32'd1);
      offer(32'h14);
      step();
      chk("stall_pc1", bus.Out_PC, 32'h10);
      chk("stall_occ1", 32'(bus.Occupancy), 32'd2);
      chk("stall_rdy1", 32'(bus.In_Ready), 32'd0);
      offer(32'h18);
      step();
      chk("stall_pc2", bus.Out_PC, 32'h10);
      chk("stall_occ2", 32'(bus.Occupancy), 32'd2);
      bus.Out_Ready = 1'b1;
      step();
      chk("drain_pc0", bus.Out_PC, 32'h14);
      chk("drain_occ0", 32'(bus.Occupancy), 32'd1);
      step();
      chk("drain_pc1", bus.Out_PC, 32'h18);
      bus.In_Valid = 1'b0;
      step();
      chk("drain_occ2", 32'(bus.Occupancy), 32'd0);

      // Flush while full with a valid offer.
      bus.Out_Ready = 1'b0;
      offer(32'h1C);
      step();
      offer(32'h30);
      step();
      chk("full_occ", 32'(bus.Occupancy), 32'd2);
      offer(32'h20);
      bus.Flush = 1'b1;
      step();
      chk("flush_occ",   32'(bus.Occupancy), 32'd0);
      chk("flush_valid", 32'(bus.Out_Valid), 32'd0);
      chk("flush_ready", 32'(bus.In_Ready), 32'd1);
`ifdef PIPE_PERF_CNT_EN
      chk("flush_cnt3", 32'(flush_cnt), 32'd3);
`endif
      bus.Flush     = 1'b0;
      bus.In_Valid  = 1'b0;
      bus.Out_Ready = 1'b1;
      step();
      chk("post_flush_valid", 32'(bus.Out_Valid), 32'd0);

      // Long stall to saturate the stall counter.
      offer(32'h40);
      step();
      bus.In_Valid  = 1'b0;
      bus.Out_Ready = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("sat_pc", bus.Out_PC, 32'h40);
`ifdef PIPE_PERF_CNT_EN
      chk("stall_sat", 32'(stall_cnt), 32'd15);
`endif

      // Reset together with Flush behaves as Reset.
      rst       = 1'b1;
      bus.Flush = 1'b1;
      offer(32'h44);
      step();
      chk("rf_occ",   32'(bus.Occupancy), 32'd0);
      chk("rf_ready", 32'(bus.In_Ready), 32'd0);
`ifdef PIPE_PERF_CNT_EN
      chk("rf_stall", 32'(stall_cnt), 32'd0);
      chk("rf_flush", 32'(flush_cnt), 32'd0);
`endif
      rst          = 1'b0;
      bus.Flush    = 1'b0;
      bus.In_Valid = 1'b0;
      step();
      chk("rf_ready2", 32'(bus.In_Ready), 32'd1);

      // Randomised traffic; every offered PC is unique so loss or duplication shows up.
      rpc = 32'h1000;
      for (int i = 0; i < 600; i++) begin
         rst           = ($urandom_range(0, 99) == 0);
         bus.Flush     = ($urandom_range(0, 19) == 0);
         bus.In_Valid  = ($urandom_range(0, 2) != 0);
         bus.Out_Ready = ($urandom_range(0, 3) != 0);
         bus.In_PC     = rpc;
         bus.In_Data   = $urandom;
         rpc           = rpc + 32'd4;
         step();
      end
      rst           = 1'b0;
      bus.Flush     = 1'b0;
      bus.In_Valid  = 1'b0;
      bus.Out_Ready = 1'b1;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
